// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART peripheral.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CTRL_SEND      = 0;
    localparam int CTRL_NEW_RX    = 1;
    localparam int CTRL_FRAME_ERR = 2;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, start-bit glitch filter, mid-bit sampler.
// Latency: rx_valid/rx_frame_err pulse one cycle after the stop-bit sample; no backpressure (a new byte overwrites rx_byte).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    output logic                      rx_frame_err
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rx_s;
    logic                      rx_prev;
    uart_state_t               rx_state;
    logic [CW-1:0]             rx_cnt;
    logic [2:0]                rx_bit;
    logic [UART_DATA_BITS-1:0] rx_shift;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q       <= '1;
            rx_prev      <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync_q       <= (sync_q << 1) | SYNC_STAGES'(rx_i);
            rx_prev      <= rx_s;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                IDLE: begin
                    // Edge detection needs a high line first, so a low line after a bad stop never re-triggers.
                    if (rx_prev && !rx_s) begin
                        rx_state <= START;
                        rx_cnt   <= CW'(1);
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rx_state <= IDLE;
                        end else begin
                            rx_state <= DATA;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[UART_DATA_BITS-1:1]};
                        if (rx_bit == 3'(UART_DATA_BITS - 1)) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (rx_s) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_interface.sv
// Memory-mapped UART: control/data registers, 8N1 transmitter, embedded receiver.
// Latency: tx_o starts the frame one cycle after the send strobe; no backpressure (busy sends are dropped).
module uart_interface
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_ctrl_i,
    input  logic        we_data_i,
    input  logic [31:0] data_i,
    output logic [31:0] out_uartc_o,
    output logic [31:0] out_uart_o,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t               tx_state;
    logic [CW-1:0]             tx_cnt;
    logic [2:0]                tx_bit;
    logic [UART_DATA_BITS-1:0] tx_hold;
    logic [UART_DATA_BITS-1:0] tx_shift;
    logic                      send;
    logic                      new_rx;
    logic                      frame_err;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid;
    logic                      rx_frame_err;
    logic                      tx_start;
    logic                      data_unused;

    assign data_unused = ^data_i[31:UART_DATA_BITS];

    // The frame starts on the strobe edge itself, so it latches tx_hold before a same-edge data write.
    assign tx_start = we_ctrl_i && data_i[CTRL_SEND] && (tx_state == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_hold  <= '0;
            tx_shift <= '0;
            send     <= 1'b0;
            tx_o     <= 1'b1;
        end else begin
            if (we_data_i) begin
                tx_hold <= data_i[UART_DATA_BITS-1:0];
            end
            case (tx_state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (tx_start) begin
                        tx_state <= START;
                        tx_shift <= tx_hold;
                        tx_cnt   <= '0;
                        send     <= 1'b1;
                        tx_o     <= 1'b0;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= DATA;
                        tx_bit   <= '0;
                        tx_o     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'(UART_DATA_BITS - 1)) begin
                            tx_state <= STOP;
                            tx_o     <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_o     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= IDLE;
                        send     <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Hardware set beats a software clear landing on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            new_rx    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                new_rx <= 1'b1;
            end else if (we_ctrl_i && !data_i[CTRL_NEW_RX]) begin
                new_rx <= 1'b0;
            end
            if (rx_frame_err) begin
                frame_err <= 1'b1;
            end else if (we_ctrl_i && !data_i[CTRL_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
        end
    end

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rx_i         (rx_i),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    assign out_uartc_o = {29'b0, frame_err, new_rx, send};
    assign out_uart_o  = {{(32 - UART_DATA_BITS){1'b0}}, rx_byte};

endmodule

// File: tb/tb_uart_interface.sv
// Directed plus randomized bench for uart_interface against a frame-level reference model.
module tb_uart_interface;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_ctrl;
    logic        we_data;
    logic [31:0] data;
    logic [31:0] uartc;
    logic [31:0] uart;
    logic        rx;
    logic        tx;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: register contents as software would see them.
    logic [7:0] exp_hold;
    logic [7:0] exp_rx;
    logic       exp_new_rx;
    logic       exp_ferr;

    uart_interface #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .we_ctrl_i   (we_ctrl),
        .we_data_i   (we_data),
        .data_i      (data),
        .out_uartc_o (uartc),
        .out_uart_o  (uart),
        .rx_i        (rx),
        .tx_o        (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ctrl(input logic send_bit);
        return {29'b0, exp_ferr, exp_new_rx, send_bit};
    endfunction

    // Line level of an 8N1 frame during bit slot 0..9.
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot > 8) return 1'b1;
        return b[slot-1];
    endfunction

    function automatic void model_ctrl(input logic [31:0] d);
        if (!d[1]) exp_new_rx = 1'b0;
        if (!d[2]) exp_ferr = 1'b0;
    endfunction

    task automatic data_write(input logic [7:0] d);
        we_data = 1'b1;
        data    = {24'b0, d};
        @(negedge clk);
        we_data  = 1'b0;
        exp_hold = d;
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        we_ctrl = 1'b1;
        data    = d;
        @(negedge clk);
        we_ctrl = 1'b0;
        model_ctrl(d);
    endtask

    // Issue a send (optionally with a same-edge data write) and check the whole serial frame.
    task automatic tx_frame(input logic [31:0] d, input logic with_data, input int poke);
        logic [7:0] b;
        b       = exp_hold;
        we_ctrl = 1'b1;
        we_data = with_data;
        data    = d;
        if (with_data) exp_hold = d[7:0];
        model_ctrl(d);
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (i == 0) begin
                we_ctrl = 1'b0;
                we_data = 1'b0;
                check("tx_send_set", uartc, exp_ctrl(1'b1));
            end
            check("tx_bit", {31'b0, tx}, {31'b0, frame_bit(b, i / CPB)});
            if (poke >= 0) begin
                if (i == poke) begin
                    we_data  = 1'b1;
                    data     = 32'hFF;
                    exp_hold = 8'hFF;
                end else if (i == poke + 1) begin
                    we_data = 1'b0;
                    we_ctrl = 1'b1;
                    data    = 32'h1;
                    model_ctrl(32'h1);
                end else if (i == poke + 2) begin
                    we_ctrl = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("tx_done_line", {31'b0, tx}, 32'h1);
        check("tx_send_clr", uartc, exp_ctrl(1'b0));
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("tx_idle_line", {31'b0, tx}, 32'h1);
            check("tx_idle_ctrl", uartc, exp_ctrl(1'b0));
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        if (stop) begin
            exp_rx     = b;
            exp_new_rx = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        check("rx_byte", uart, {24'b0, exp_rx});
        check("rx_flags", uartc, exp_ctrl(1'b0));
    endtask

    initial begin
        logic [7:0]  b;
        logic        stop;
        logic [31:0] cd;

        rst_n      = 1'b0;
        we_ctrl    = 1'b0;
        we_data    = 1'b0;
        data       = '0;
        rx         = 1'b1;
        exp_hold   = '0;
        exp_rx     = '0;
        exp_new_rx = 1'b0;
        exp_ferr   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_ctrl", uartc, 32'h0);
        check("reset_data", uart, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_tx", {31'b0, tx}, 32'h1);
        check("post_reset_ctrl", uartc, 32'h0);

        // Basic frame, then a back-to-back frame.
        data_write(8'h55);
        tx_frame(32'h1, 1'b0, -1);
        tx_frame(32'h1, 1'b0, -1);

        // Data and send writes mid-frame: frame unchanged, busy send dropped.
        tx_frame(32'h1, 1'b0, 10);
        idle_check(6);
        tx_frame(32'h1, 1'b0, -1);

        // Same-edge data and send: frame uses the previous holding value.
        tx_frame(32'h81, 1'b1, -1);
        tx_frame(32'h1, 1'b0, -1);

        for (int n = 0; n < 3; n++) begin
            data_write(8'($urandom));
            tx_frame(32'h1, 1'b0, -1);
        end

        // Receive path.
        rx_frame(8'hA3, 1'b1);
        check("rx_a3_data", uart, 32'h0000_00A3);
        check("rx_a3_ctrl", uartc, 32'h2);
        ctrl_write(32'h0);
        check("rx_clear_ctrl", uartc, 32'h0);

        rx_frame(8'h3C, 1'b0);
        check("rx_ferr_ctrl", uartc, 32'h4);
        check("rx_ferr_data", uart, 32'h0000_00A3);
        ctrl_write(32'h0);
        check("rx_ferr_clear", uartc, 32'h0);

        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_ctrl", uartc, exp_ctrl(1'b0));
        check("glitch_data", uart, {24'b0, exp_rx});
        rx_frame(8'h5A, 1'b1);

        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rx_frame(b, stop);
            if ($urandom_range(0, 1) == 1) begin
                cd = {29'b0, 2'($urandom_range(0, 3)), 1'b0};
                ctrl_write(cd);
                check("rx_rand_clear", uartc, exp_ctrl(1'b0));
            end
        end

        // Asynchronous reset in the middle of a start bit.
        rx_frame(8'hE7, 1'b1);
        data_write(8'hC3);
        we_ctrl = 1'b1;
        data    = 32'h1;
        @(negedge clk);
        we_ctrl = 1'b0;
        @(negedge clk);
        check("pre_reset_tx_low", {31'b0, tx}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'h1);
        check("async_reset_ctrl", uartc, 32'h0);
        check("async_reset_data", uart, 32'h0);
        exp_hold   = '0;
        exp_rx     = '0;
        exp_new_rx = 1'b0;
        exp_ferr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check(2);
        data_write(8'($urandom));
        tx_frame(32'h1, 1'b0, -1);
        rx_frame(8'($urandom), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
